// File: rtl/data_ram_pkg.sv
// Shared constants and types for the CPU data-side memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package data_ram_pkg;

  // Data path width of the CPU data bus.
  localparam int DataWidth = 32;

  // Default memory geometry: DataMemNum words, DataMemNumLog2 index bits.
  localparam int DataMemNumLog2 = 10;
  localparam int DataMemNum     = 1 << DataMemNumLog2;

  // Request direction encoding on the we line.
  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  // Number of byte lanes in one data word.
  localparam int LaneNum = DataWidth / 8;

  // Top-level sequencer states: zeroing the array, then serving requests.
  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

endpackage

// File: rtl/data_ram_if.sv
// MEM-stage to data-memory request/response bundle.
// Latency: reads combinational, writes commit on the next rising edge.
// Backpressure: none; requests are simply ignored while ready is low.
interface data_ram_if;
  import data_ram_pkg::*;

  logic                 ce;
  logic                 we;
  logic [LaneNum-1:0]   sel;
  logic [31:0]          addr;
  logic [DataWidth-1:0] data_i;
  logic [DataWidth-1:0] data_o;
  logic                 ready;
  logic                 addr_err;

  // MEM stage side: issues requests, observes the read word and status.
  modport master (
    output ce, we, sel, addr, data_i,
    input  data_o, ready, addr_err
  );

  // Memory side: accepts requests, returns the read word and status.
  modport slave (
    input  ce, we, sel, addr, data_i,
    output data_o, ready, addr_err
  );

endinterface

// File: rtl/data_ram.sv
// Word-organised data memory with big-endian byte-lane writes and self-zeroing after reset.
// Latency: read 0 cycles (combinational), write 1 edge, init DEPTH cycles after reset release.
// Backpressure: ready low during init; requests then are dropped, not stalled.
module data_ram
  import data_ram_pkg::*;
#(
  parameter int ADDR_W = DataMemNumLog2
) (
  input  logic       clk,
  input  logic       rst_n,
  data_ram_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;

  // Sequencer state; ready is a registered copy so it drops with the async reset.
  state_t               state;
  logic [ADDR_W-1:0]    cnt;
  logic                 ready_q;

  // Storage: plain inferred array, never reset, cleared only by the init walk.
  logic [DataWidth-1:0] mem [DEPTH];

  // Request decode.
  logic [ADDR_W-1:0]    word_idx;
  logic                 out_of_range;
  logic                 access;
  logic                 hit;
  logic [DataWidth-1:0] cur_word;
  logic [DataWidth-1:0] merged_word;

  // Array write port, shared between the init walk and normal writes.
  logic                 wr_en;
  logic [ADDR_W-1:0]    wr_idx;
  logic [DataWidth-1:0] wr_dat;

  // Byte offset is the MEM stage's business; it is deliberately not decoded here.
  logic                 unused_addr_lsb;

  assign word_idx        = bus.addr[ADDR_W+1:2];
  assign out_of_range    = |bus.addr[31:ADDR_W+2];
  assign access          = ready_q & bus.ce;
  assign hit             = access & ~out_of_range;
  assign cur_word        = mem[word_idx];
  assign unused_addr_lsb = ^bus.addr[1:0];

  // Lane merge: selected lanes take write data, others keep the stored byte.
  for (genvar i = 0; i < LaneNum; i++) begin : g_lane
    assign merged_word[8*i +: 8] = bus.sel[i] ? bus.data_i[8*i +: 8] : cur_word[8*i +: 8];
  end

  // The init walk owns the write port until the last word has been cleared.
  assign wr_en  = (state == ST_INIT) | (hit & (bus.we == WRITE) & (|bus.sel));
  assign wr_idx = (state == ST_INIT) ? cnt : word_idx;
  assign wr_dat = (state == ST_INIT) ? '0 : merged_word;

  // Response: the addressed word (pre-edge contents) for any in-range access, else zero.
  assign bus.data_o   = hit ? cur_word : '0;
  assign bus.addr_err = access & out_of_range;
  assign bus.ready    = ready_q;

  // Sequencer: walk cnt across the array once, then park in READY until the next reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_INIT;
      cnt     <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == {ADDR_W{1'b1}}) begin
            state   <= ST_READY;
            ready_q <= 1'b1;
          end
        end
        ST_READY: begin
          state   <= ST_READY;
          ready_q <= 1'b1;
        end
        default: begin
          state   <= ST_INIT;
          cnt     <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Array write: one full-word write per edge, lanes already merged.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_dat;
    end
  end

endmodule
